// File: rtl/ide_pkg.sv
// rtl/ide_pkg.sv - shared IDE command codes, FSM state encodings and command class decode
package ide_pkg;

  localparam logic [7:0] CMD_READ_SECTORS    = 8'h20;
  localparam logic [7:0] CMD_READ_SECTORS_NR = 8'h21;
  localparam logic [7:0] CMD_IDENTIFY        = 8'hEC;
  localparam logic [7:0] CMD_WRITE_SECTORS   = 8'h30;
  localparam logic [7:0] CMD_WRITE_SECTORS_NR = 8'h31;

  localparam int STAT_ERR_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET   = 3'd1,
    ST_FILL  = 3'd2,
    ST_STAT  = 3'd3,
    ST_XFER  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONDATA = 2'd0,
    CLS_READ    = 2'd1,
    CLS_WRITE   = 2'd2
  } cmd_class_e;

  function automatic cmd_class_e decode_class(input logic [7:0] code);
    cmd_class_e cls;
    case (code)
      CMD_READ_SECTORS, CMD_READ_SECTORS_NR, CMD_IDENTIFY: cls = CLS_READ;
      CMD_WRITE_SECTORS, CMD_WRITE_SECTORS_NR:             cls = CLS_WRITE;
      default:                                             cls = CLS_NONDATA;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ide_timeout.sv
// rtl/ide_timeout.sv - ESP32-wait watchdog; expired fires on the TO_LIMIT-th cycle spent waiting
module ide_timeout #(
  parameter int                 TO_BITS  = 24,
  parameter logic [TO_BITS-1:0] TO_LIMIT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_BITS-1:0] LIMIT_M1 = TO_LIMIT - 1'b1;

  logic [TO_BITS-1:0] timer_q;
  logic [TO_BITS-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable && (timer_q != LIMIT_M1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Counting the entry cycle means ERROR lands exactly TO_LIMIT edges after entering the wait state.
  assign expired = enable && (timer_q == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/ide_cmd_sequencer.sv
// rtl/ide_cmd_sequencer.sv - IDE command FSM between CPU task file and ESP32 SPI side
module ide_cmd_sequencer
  import ide_pkg::*;
#(
  parameter int                 TO_BITS  = 24,
  parameter logic [TO_BITS-1:0] TO_LIMIT = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_code,
  input  logic [7:0] sec_cnt,
  input  logic       cpu_buf_done,
  input  logic       spi_get_done,
  input  logic       spi_rd_done,
  input  logic       spi_wr_done,
  input  logic       spi_put_done,
  input  logic [7:0] spi_stat,
  output logic       bsy,
  output logic       drq,
  output logic       err,
  output logic       irq,
  output logic [2:0] phase
);

  state_e     state_q, state_d;
  cmd_class_e class_q, class_d;
  logic [8:0] remaining_q, remaining_d;
  logic       bsy_q, bsy_d;
  logic       drq_q, drq_d;
  logic       err_q, err_d;
  logic       irq_q, irq_d;
  logic [2:0] phase_q, phase_d;

  logic       to_clear;
  logic       to_enable;
  logic       to_expired;
  logic [8:0] rem_dec;
  logic       unused_stat;

  assign unused_stat = ^spi_stat[7:1];

  assign rem_dec   = (remaining_q != 9'd0) ? remaining_q - 9'd1 : 9'd0;
  assign to_clear  = (state_d != state_q);
  assign to_enable = (state_q == ST_GET) || (state_q == ST_FILL) ||
                     (state_q == ST_STAT) || (state_q == ST_DRAIN);

  ide_timeout #(
    .TO_BITS  (TO_BITS),
    .TO_LIMIT (TO_LIMIT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (cmd_wr) begin
          state_d     = ST_GET;
          class_d     = decode_class(cmd_code);
          remaining_d = (sec_cnt == 8'd0) ? 9'd256 : {1'b0, sec_cnt};
        end
      end
      ST_GET: begin
        if (to_expired) begin
          state_d = ST_ERROR;
        end else if (spi_get_done) begin
          case (class_q)
            CLS_READ:  state_d = ST_FILL;
            CLS_WRITE: state_d = ST_XFER;
            default:   state_d = ST_STAT;
          endcase
        end
      end
      ST_FILL: begin
        if (to_expired) begin
          state_d = ST_ERROR;
        end else if (spi_wr_done) begin
          state_d = ST_STAT;
        end
      end
      ST_STAT: begin
        if (to_expired) begin
          state_d = ST_ERROR;
        end else if (spi_put_done) begin
          if (spi_stat[STAT_ERR_BIT]) begin
            state_d = ST_ERROR;
          end else begin
            case (class_q)
              CLS_READ: state_d = ST_XFER;
              CLS_WRITE: begin
                remaining_d = rem_dec;
                state_d     = (rem_dec == 9'd0) ? ST_IDLE : ST_XFER;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_XFER: begin
        if (cpu_buf_done) begin
          case (class_q)
            CLS_READ: begin
              remaining_d = rem_dec;
              state_d     = (rem_dec == 9'd0) ? ST_IDLE : ST_FILL;
            end
            CLS_WRITE: state_d = ST_DRAIN;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_DRAIN: begin
        if (to_expired) begin
          state_d = ST_ERROR;
        end else if (spi_rd_done) begin
          state_d = ST_STAT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with phase after the edge.
  always_comb begin
    bsy_d   = (state_d == ST_GET) || (state_d == ST_FILL) ||
              (state_d == ST_STAT) || (state_d == ST_DRAIN);
    drq_d   = (state_d == ST_XFER);
    err_d   = (state_d == ST_ERROR);
    irq_d   = (state_d == ST_GET) || (state_d == ST_FILL) || (state_d == ST_DRAIN);
    phase_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      class_q     <= CLS_NONDATA;
      remaining_q <= 9'd0;
      bsy_q       <= 1'b0;
      drq_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      phase_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      class_q     <= class_d;
      remaining_q <= remaining_d;
      bsy_q       <= bsy_d;
      drq_q       <= drq_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      phase_q     <= phase_d;
    end
  end

  assign bsy   = bsy_q;
  assign drq   = drq_q;
  assign err   = err_q;
  assign irq   = irq_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_ide_cmd_sequencer.sv
// tb/tb_ide_cmd_sequencer.sv - directed self-checking bench for ide_cmd_sequencer
module tb_ide_cmd_sequencer;

  localparam int P_CMD = 0;
  localparam int P_BUF = 1;
  localparam int P_GET = 2;
  localparam int P_RD  = 3;
  localparam int P_WR  = 4;
  localparam int P_PUT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_code = 8'h00;
  logic [7:0] sec_cnt = 8'h00;
  logic       cpu_buf_done = 1'b0;
  logic       spi_get_done = 1'b0;
  logic       spi_rd_done = 1'b0;
  logic       spi_wr_done = 1'b0;
  logic       spi_put_done = 1'b0;
  logic [7:0] spi_stat = 8'h00;
  logic       bsy, drq, err, irq;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  ide_cmd_sequencer #(
    .TO_BITS  (24),
    .TO_LIMIT (24'd16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_wr       (cmd_wr),
    .cmd_code     (cmd_code),
    .sec_cnt      (sec_cnt),
    .cpu_buf_done (cpu_buf_done),
    .spi_get_done (spi_get_done),
    .spi_rd_done  (spi_rd_done),
    .spi_wr_done  (spi_wr_done),
    .spi_put_done (spi_put_done),
    .spi_stat     (spi_stat),
    .bsy          (bsy),
    .drq          (drq),
    .err          (err),
    .irq          (irq),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  task automatic pulse(input int k, input logic [7:0] st);
    case (k)
      P_CMD: cmd_wr = 1'b1;
      P_BUF: cpu_buf_done = 1'b1;
      P_GET: spi_get_done = 1'b1;
      P_RD:  spi_rd_done = 1'b1;
      P_WR:  spi_wr_done = 1'b1;
      default: begin
        spi_put_done = 1'b1;
        spi_stat = st;
      end
    endcase
    @(posedge clk);
    #1;
    cmd_wr = 1'b0;
    cpu_buf_done = 1'b0;
    spi_get_done = 1'b0;
    spi_rd_done = 1'b0;
    spi_wr_done = 1'b0;
    spi_put_done = 1'b0;
    spi_stat = 8'h00;
  endtask

  // Expected word layout: {phase[2:0], bsy, drq, err, irq}
  task automatic expect_out(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {phase, bsy, drq, err, irq};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got phase=%0d bsy=%b drq=%b err=%b irq=%b, want phase=%0d bsy=%b drq=%b err=%b irq=%b",
               name, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    expect_out("reset", {3'd0, 4'b0000});
  endtask

  task automatic test_read_one();
    cmd_code = 8'h20;
    sec_cnt = 8'd1;
    pulse(P_CMD, 8'h00);
    expect_out("read1_get", {3'd1, 4'b1001});
    pulse(P_GET, 8'h00);
    expect_out("read1_fill", {3'd2, 4'b1001});
    pulse(P_WR, 8'h00);
    expect_out("read1_stat", {3'd3, 4'b1000});
    pulse(P_PUT, 8'h00);
    expect_out("read1_xfer", {3'd4, 4'b0100});
    pulse(P_BUF, 8'h00);
    expect_out("read1_idle", {3'd0, 4'b0000});
  endtask

  task automatic test_write_three();
    int drains;
    drains = 0;
    cmd_code = 8'h30;
    sec_cnt = 8'd3;
    pulse(P_CMD, 8'h00);
    expect_out("wr3_get", {3'd1, 4'b1001});
    pulse(P_GET, 8'h00);
    expect_out("wr3_xfer0", {3'd4, 4'b0100});
    for (int i = 0; i < 3; i++) begin
      pulse(P_BUF, 8'h00);
      if (phase == 3'd5) drains++;
      expect_out("wr3_drain", {3'd5, 4'b1001});
      pulse(P_RD, 8'h00);
      expect_out("wr3_stat", {3'd3, 4'b1000});
      pulse(P_PUT, 8'h00);
      if (i < 2) expect_out("wr3_xfer", {3'd4, 4'b0100});
      else       expect_out("wr3_idle", {3'd0, 4'b0000});
    end
    n_cmp++;
    if (drains !== 3) begin
      n_bad++;
      $display("FAIL wr3_drain_count: got %0d, want 3", drains);
    end
  endtask

  task automatic test_read_256();
    int loops;
    int guard;
    loops = 0;
    guard = 0;
    cmd_code = 8'h20;
    sec_cnt = 8'd0;
    pulse(P_CMD, 8'h00);
    pulse(P_GET, 8'h00);
    while (phase == 3'd2 && guard < 300) begin
      guard++;
      pulse(P_WR, 8'h00);
      pulse(P_PUT, 8'h00);
      if (phase != 3'd4) break;
      pulse(P_BUF, 8'h00);
      loops++;
    end
    n_cmp++;
    if (loops !== 256) begin
      n_bad++;
      $display("FAIL rd256_loops: got %0d, want 256", loops);
    end
    expect_out("rd256_idle", {3'd0, 4'b0000});
    pulse(P_BUF, 8'h00);
    expect_out("rd256_stray_buf", {3'd0, 4'b0000});
  endtask

  task automatic test_put_error();
    cmd_code = 8'h21;
    sec_cnt = 8'd2;
    pulse(P_CMD, 8'h00);
    pulse(P_GET, 8'h00);
    pulse(P_WR, 8'h00);
    pulse(P_PUT, 8'h01);
    expect_out("puterr_error", {3'd6, 4'b0010});
    pulse(P_BUF, 8'h00);
    expect_out("puterr_hold", {3'd6, 4'b0010});
    cmd_code = 8'hEC;
    sec_cnt = 8'd1;
    pulse(P_CMD, 8'h00);
    expect_out("puterr_recover", {3'd1, 4'b1001});
    do_reset();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    cmd_code = 8'h90;
    sec_cnt = 8'd1;
    pulse(P_CMD, 8'h00);
    expect_out("to_get", {3'd1, 4'b1001});
    while (phase == 3'd1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL to_cycles: got %0d, want 16", n);
    end
    expect_out("to_error", {3'd6, 4'b0010});
  endtask

  task automatic test_ignore_and_reset();
    do_reset();
    cmd_code = 8'h20;
    sec_cnt = 8'd2;
    pulse(P_CMD, 8'h00);
    pulse(P_GET, 8'h00);
    cmd_code = 8'h30;
    sec_cnt = 8'd1;
    pulse(P_CMD, 8'h00);
    expect_out("fill_cmd_ignored", {3'd2, 4'b1001});
    pulse(P_GET, 8'h00);
    expect_out("fill_get_ignored", {3'd2, 4'b1001});
    // Simultaneous strobes: only the FILL-expected write-done acts.
    spi_rd_done = 1'b1;
    spi_put_done = 1'b1;
    pulse(P_WR, 8'h00);
    expect_out("multi_strobe", {3'd3, 4'b1000});
    pulse(P_PUT, 8'h00);
    expect_out("ign_xfer", {3'd4, 4'b0100});
    pulse(P_BUF, 8'h00);
    expect_out("ign_read_class_kept", {3'd2, 4'b1001});
    pulse(P_WR, 8'h00);
    pulse(P_PUT, 8'h00);
    expect_out("ign_xfer2", {3'd4, 4'b0100});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_out("xfer_reset", {3'd0, 4'b0000});
  endtask

  initial begin
    test_reset();
    test_read_one();
    test_write_three();
    test_read_256();
    test_put_error();
    test_timeout();
    test_ignore_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
